ring_request_arbiter: RTL and testbench

Front end of a node's ring controller: collects L1 data- and instruction-cache miss requests from all threads and injects them as read requests into free ring slots. Entries are retired when the response is consumed downstream. Sits between the upstream ring link and ring controller stage 1, and receives wake-ups from stage 3. Arbitration is round-robin between caches and between threads, so no single thread can monopolise free slots.

---
 rtl/ring_request_arbiter_pkg.sv | 50 +++++
 rtl/ring_request_arbiter_if.sv | 40 ++++
 rtl/ring_request_arbiter_rr_arbiter.sv | 55 +++++
 rtl/ring_request_arbiter.sv | 177 +++++++++++++++++
 tb/tb_ring_request_arbiter.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ring_request_arbiter_pkg.sv
// Shared ring types for the node ring controller: packet layout, packet and
// cache type encodings, and line-address helpers.
package ring_request_arbiter_pkg;

  localparam int THREADS_PER_CORE = 4;
  localparam int CACHE_LINE_BYTES = 64;
  localparam int TID_W            = $clog2(THREADS_PER_CORE);
  localparam int LINE_OFS_W       = $clog2(CACHE_LINE_BYTES);
  localparam int NODE_W           = 4;

  typedef logic [31:0]       scalar_t;
  typedef logic [TID_W-1:0]  tid_t;
  typedef logic [NODE_W-1:0] node_id_t;

  typedef enum logic [1:0] {
    PKT_NONE             = 2'd0,
    PKT_READ_SHARED      = 2'd1,
    PKT_WRITE_INVALIDATE = 2'd2,
    PKT_FLUSH            = 2'd3
  } packet_type_t;

  typedef enum logic {
    CT_ICACHE = 1'b0,
    CT_DCACHE = 1'b1
  } cache_type_t;

  typedef struct packed {
    logic         valid;
    logic         ack;
    packet_type_t packet_type;
    cache_type_t  cache_type;
    node_id_t     dest_node;
    scalar_t      address;
    scalar_t      data;
  } ring_packet_t;

  function automatic scalar_t line_address(input scalar_t addr);
    return {addr[$bits(scalar_t)-1:LINE_OFS_W], {LINE_OFS_W{1'b0}}};
  endfunction

  function automatic tid_t onehot_to_tid(input logic [THREADS_PER_CORE-1:0] oh);
    tid_t r;
    r = '0;
    for (int i = 0; i < THREADS_PER_CORE; i++) begin
      if (oh[i]) r = tid_t'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/ring_request_arbiter_if.sv
// Bundle of cache-miss, wake, ring-slot and status signals around the
// ring request arbiter.
interface ring_request_arbiter_if;
  import ring_request_arbiter_pkg::*;

  logic                        dcache_miss_en;
  tid_t                        dcache_miss_thread;
  scalar_t                     dcache_miss_addr;
  logic                        icache_miss_en;
  tid_t                        icache_miss_thread;
  scalar_t                     icache_miss_addr;
  ring_packet_t                packet_in;
  ring_packet_t                packet_out;
  logic                        rc3_dcache_wake;
  tid_t                        rc3_dcache_wake_entry;
  logic                        rc3_icache_wake;
  tid_t                        rc3_icache_wake_entry;
  logic [THREADS_PER_CORE-1:0] dcache_miss_pending;
  logic [THREADS_PER_CORE-1:0] icache_miss_pending;
  logic                        rra_starved;

  modport master (
    output dcache_miss_en, dcache_miss_thread, dcache_miss_addr,
    output icache_miss_en, icache_miss_thread, icache_miss_addr,
    output packet_in,
    output rc3_dcache_wake, rc3_dcache_wake_entry,
    output rc3_icache_wake, rc3_icache_wake_entry,
    input  packet_out, dcache_miss_pending, icache_miss_pending, rra_starved
  );

  modport slave (
    input  dcache_miss_en, dcache_miss_thread, dcache_miss_addr,
    input  icache_miss_en, icache_miss_thread, icache_miss_addr,
    input  packet_in,
    input  rc3_dcache_wake, rc3_dcache_wake_entry,
    input  rc3_icache_wake, rc3_icache_wake_entry,
    output packet_out, dcache_miss_pending, icache_miss_pending, rra_starved
  );

endinterface

// File: rtl/ring_request_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from a rotating pointer that
// moves past the winner when update_en is asserted.
module rr_arbiter #(
  parameter int NUM_REQUESTERS = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQUESTERS-1:0] request,
  input  logic                      update_en,
  output logic [NUM_REQUESTERS-1:0] grant
);

  localparam int PTR_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
  localparam logic [PTR_W:0] N_EXT = (PTR_W+1)'(NUM_REQUESTERS);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] cand;
  logic             found;

  // Wrap uses an extra bit so non-power-of-two requester counts stay in range.
  function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] base,
                                                input int ofs);
    logic [PTR_W:0] sum;
    sum = {1'b0, base} + (PTR_W+1)'(ofs);
    if (sum >= N_EXT) sum = sum - N_EXT;
    return sum[PTR_W-1:0];
  endfunction

  always_comb begin
    grant     = '0;
    grant_idx = ptr_q;
    cand      = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      cand = rr_index(ptr_q, i);
      if (!found && request[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (update_en && found) ptr_d = rr_index(grant_idx, 1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ring_request_arbiter.sv
// Ring request arbiter: per-thread dcache/icache miss tables whose queued
// requests are injected as read-shared packets into free ring slots.
module ring_request_arbiter
  import ring_request_arbiter_pkg::*;
#(
  parameter int NODE_ID      = 0,
  parameter int STARVE_LIMIT = 64
) (
  input logic                   clk,
  input logic                   reset_n,
  ring_request_arbiter_if.slave bus
);

  typedef enum logic [1:0] {EMPTY, QUEUED, SENT} miss_entry_state_t;

  localparam int T     = THREADS_PER_CORE;
  localparam int DC    = 0;
  localparam int IC    = 1;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic    miss_en     [2];
  tid_t    miss_thread [2];
  scalar_t miss_addr   [2];
  logic    wake        [2];
  tid_t    wake_entry  [2];

  miss_entry_state_t state_q [2][T];
  miss_entry_state_t state_d [2][T];
  scalar_t           addr_q  [2][T];
  scalar_t           addr_d  [2][T];
  logic [T-1:0]      stale_q [2];
  logic [T-1:0]      stale_d [2];
  logic [T-1:0]      queued  [2];
  logic [T-1:0]      grant   [2];
  logic [T-1:0]      pending [2];
  logic [1:0]        has_queued;
  logic [1:0]        grant_en;

  cache_type_t       favor_q, favor_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  ring_packet_t      packet_out_q, packet_out_d;
  ring_packet_t      inj_pkt;
  tid_t              inj_tid;
  logic              inject;
  logic              pick_ic;

  assign miss_en[DC]     = bus.dcache_miss_en;
  assign miss_thread[DC] = bus.dcache_miss_thread;
  assign miss_addr[DC]   = bus.dcache_miss_addr;
  assign wake[DC]        = bus.rc3_dcache_wake;
  assign wake_entry[DC]  = bus.rc3_dcache_wake_entry;
  assign miss_en[IC]     = bus.icache_miss_en;
  assign miss_thread[IC] = bus.icache_miss_thread;
  assign miss_addr[IC]   = bus.icache_miss_addr;
  assign wake[IC]        = bus.rc3_icache_wake;
  assign wake_entry[IC]  = bus.rc3_icache_wake_entry;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= CNT_MAX) ? v : v + 1'b1;
  endfunction

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      for (int t = 0; t < T; t++) begin
        queued[c][t]  = (state_q[c][t] == QUEUED);
        pending[c][t] = (state_q[c][t] != EMPTY);
      end
    end
  end

  for (genvar c = 0; c < 2; c++) begin : g_table
    assign has_queued[c] = |queued[c];

    rr_arbiter #(.NUM_REQUESTERS(T)) u_rr (
      .clk      (clk),
      .reset_n  (reset_n),
      .request  (queued[c]),
      .update_en(grant_en[c]),
      .grant    (grant[c])
    );
  end

  // Cache choice: favor only matters when both tables have queued work.
  assign pick_ic      = !(has_queued[DC] && (!has_queued[IC] || favor_q == CT_DCACHE));
  assign inject       = !bus.packet_in.valid && (|has_queued);
  assign grant_en[DC] = inject && !pick_ic;
  assign grant_en[IC] = inject && pick_ic;

  always_comb begin
    favor_d = favor_q;
    if (inject && (&has_queued)) begin
      favor_d = (favor_q == CT_DCACHE) ? CT_ICACHE : CT_DCACHE;
    end
  end

  always_comb begin
    inj_tid             = onehot_to_tid(grant[pick_ic]);
    inj_pkt             = '0;
    inj_pkt.valid       = 1'b1;
    inj_pkt.ack         = 1'b0;
    inj_pkt.packet_type = PKT_READ_SHARED;
    inj_pkt.cache_type  = pick_ic ? CT_ICACHE : CT_DCACHE;
    inj_pkt.dest_node   = node_id_t'(NODE_ID);
    inj_pkt.address     = addr_q[pick_ic][inj_tid];
    inj_pkt.data        = '0;
    packet_out_d        = inject ? inj_pkt : bus.packet_in;
  end

  // Grant, then wake, then miss: a same-cycle wake frees the entry for the new miss.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      stale_d[c] = stale_q[c];
      for (int t = 0; t < T; t++) begin
        state_d[c][t] = state_q[c][t];
        addr_d[c][t]  = addr_q[c][t];
        if (grant_en[c] && grant[c][t]) state_d[c][t] = SENT;
        if (wake[c] && wake_entry[c] == tid_t'(t) && state_q[c][t] == SENT) begin
          state_d[c][t] = EMPTY;
        end
        if (miss_en[c] && miss_thread[c] == tid_t'(t) && state_d[c][t] == EMPTY) begin
          state_d[c][t] = QUEUED;
          addr_d[c][t]  = line_address(miss_addr[c]);
          stale_d[c][t] = 1'b0;
        end
      end
    end
  end

  assign cnt_d = ((|has_queued) && bus.packet_in.valid) ? sat_inc(cnt_q) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < 2; c++) begin
        stale_q[c] <= '1;
        for (int t = 0; t < T; t++) state_q[c][t] <= EMPTY;
      end
      favor_q      <= CT_DCACHE;
      cnt_q        <= '0;
      packet_out_q <= '0;
    end else begin
      state_q      <= state_d;
      stale_q      <= stale_d;
      favor_q      <= favor_d;
      cnt_q        <= cnt_d;
      packet_out_q <= packet_out_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
  end

  assign bus.packet_out          = packet_out_q;
  assign bus.dcache_miss_pending = pending[DC];
  assign bus.icache_miss_pending = pending[IC];
  assign bus.rra_starved         = (cnt_q >= CNT_MAX);

  // Entries untouched since reset may still see wakes for responses issued before it.
  logic [1:0] miss_illegal, wake_illegal;

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      miss_illegal[c] = miss_en[c] && (state_q[c][miss_thread[c]] != EMPTY) &&
                        !(wake[c] && wake_entry[c] == miss_thread[c] &&
                          state_q[c][miss_thread[c]] == SENT);
      wake_illegal[c] = wake[c] && (state_q[c][wake_entry[c]] != SENT) &&
                        !stale_q[c][wake_entry[c]];
    end
  end

  a_miss_to_busy_entry: assert property (@(posedge clk) disable iff (!reset_n)
    miss_illegal == 2'b00);
  a_wake_to_unsent_entry: assert property (@(posedge clk) disable iff (!reset_n)
    wake_illegal == 2'b00);

endmodule

// File: tb/tb_ring_request_arbiter.sv
// Directed bench for ring_request_arbiter; expected ring packets go through a
// scoreboard queue checked by an independent output monitor.
module tb_ring_request_arbiter;
  import ring_request_arbiter_pkg::*;

  localparam int NODE = 5;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  ring_request_arbiter_if rif();

  ring_request_arbiter #(.NODE_ID(NODE), .STARVE_LIMIT(64)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (rif)
  );

  typedef struct {
    ring_packet_t pkt;
    int           cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [127:0] act, logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Monitor: every valid output slot must match the oldest expectation, in the expected cycle.
  always @(negedge clk) begin
    if (rif.packet_out.valid === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pkt: actual=%0h at cycle %0d, required none",
                 rif.packet_out, cyc);
      end else begin
        mon_e = q.pop_front();
        check("pkt_out", 128'({rif.packet_out, cyc}), 128'({mon_e.pkt, mon_e.cyc}));
      end
    end
    while (q.size() > 0 && q[0].cyc < cyc) begin
      mon_e = q.pop_front();
      total++;
      bad++;
      $display("FAIL missing_pkt: actual=none required=%0h at cycle %0d", mon_e.pkt, mon_e.cyc);
    end
  end

  function automatic ring_packet_t mk_read(cache_type_t ct, scalar_t line);
    ring_packet_t p;
    p             = '0;
    p.valid       = 1'b1;
    p.packet_type = PKT_READ_SHARED;
    p.cache_type  = ct;
    p.dest_node   = node_id_t'(NODE);
    p.address     = line;
    return p;
  endfunction

  function automatic ring_packet_t mk_busy(int n);
    ring_packet_t p;
    p             = '0;
    p.valid       = 1'b1;
    p.ack         = n[0];
    p.packet_type = PKT_WRITE_INVALIDATE;
    p.cache_type  = CT_DCACHE;
    p.dest_node   = node_id_t'(n);
    p.address     = 32'h8000_0000 + 32'(n);
    p.data        = ~32'(n);
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    rif.dcache_miss_en  = 1'b0;
    rif.icache_miss_en  = 1'b0;
    rif.rc3_dcache_wake = 1'b0;
    rif.rc3_icache_wake = 1'b0;
  endtask

  task automatic push(ring_packet_t p);
    exp_t e;
    e.pkt = p;
    e.cyc = cyc + 1;
    q.push_back(e);
  endtask

  task automatic free_slot();
    rif.packet_in = '0;
    tick();
  endtask

  task automatic free_inject(ring_packet_t p);
    push(p);
    rif.packet_in = '0;
    tick();
  endtask

  task automatic busy_slot(int n);
    ring_packet_t p;
    p = mk_busy(n);
    push(p);
    rif.packet_in = p;
    tick();
  endtask

  task automatic dmiss(tid_t t, scalar_t a);
    rif.dcache_miss_en = 1'b1; rif.dcache_miss_thread = t; rif.dcache_miss_addr = a;
  endtask

  task automatic imiss(tid_t t, scalar_t a);
    rif.icache_miss_en = 1'b1; rif.icache_miss_thread = t; rif.icache_miss_addr = a;
  endtask

  task automatic dwake(tid_t t);
    rif.rc3_dcache_wake = 1'b1; rif.rc3_dcache_wake_entry = t;
  endtask

  task automatic iwake(tid_t t);
    rif.rc3_icache_wake = 1'b1; rif.rc3_icache_wake_entry = t;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n                   = 1'b0;
    rif.packet_in             = '0;
    rif.dcache_miss_en        = 1'b0;
    rif.dcache_miss_thread    = '0;
    rif.dcache_miss_addr      = '0;
    rif.icache_miss_en        = 1'b0;
    rif.icache_miss_thread    = '0;
    rif.icache_miss_addr      = '0;
    rif.rc3_dcache_wake       = 1'b0;
    rif.rc3_dcache_wake_entry = '0;
    rif.rc3_icache_wake       = 1'b0;
    rif.rc3_icache_wake_entry = '0;

    // Reset and idle empty slots
    tick();
    tick();
    check("rst_pkt_out", 128'(rif.packet_out), 128'(0));
    check("rst_dpend", 128'(rif.dcache_miss_pending), 128'(0));
    check("rst_ipend", 128'(rif.icache_miss_pending), 128'(0));
    check("rst_starved", 128'(rif.rra_starved), 128'(0));
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      free_slot();
      check("idle_pkt_out", 128'(rif.packet_out), 128'(0));
    end
    check("idle_pend", 128'({rif.dcache_miss_pending, rif.icache_miss_pending}), 128'(0));
    check("idle_starved", 128'(rif.rra_starved), 128'(0));

    // Single dcache miss, injection, wake
    dmiss(2'd2, 32'h0000_1234);
    free_slot();
    check("single_dpend_queued", 128'(rif.dcache_miss_pending), 128'(4'b0100));
    free_inject(mk_read(CT_DCACHE, 32'h0000_1200));
    check("single_dpend_sent", 128'(rif.dcache_miss_pending), 128'(4'b0100));
    dwake(2'd2);
    free_slot();
    check("single_dpend_woken", 128'(rif.dcache_miss_pending), 128'(0));

    // Fresh pointers/favor, then D0, I0, D1, D3 queued behind busy slots
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    free_slot();
    dmiss(2'd0, 32'h0000_10FF);
    imiss(2'd0, 32'h0000_2005);
    busy_slot(1);
    dmiss(2'd1, 32'h3000_0077);
    busy_slot(2);
    dmiss(2'd3, 32'hFFFF_FFFF);
    busy_slot(3);
    free_inject(mk_read(CT_DCACHE, 32'h0000_10C0));
    free_inject(mk_read(CT_ICACHE, 32'h0000_2000));
    free_inject(mk_read(CT_DCACHE, 32'h3000_0040));
    free_inject(mk_read(CT_DCACHE, 32'hFFFF_FFC0));
    free_slot();
    check("rr_dpend_sent", 128'(rif.dcache_miss_pending), 128'(4'b1011));
    check("rr_ipend_sent", 128'(rif.icache_miss_pending), 128'(4'b0001));
    dwake(2'd0);
    iwake(2'd0);
    free_slot();
    dwake(2'd1);
    free_slot();
    dwake(2'd3);
    free_slot();
    check("rr_pend_clear", 128'({rif.dcache_miss_pending, rif.icache_miss_pending}), 128'(0));

    // Starvation: icache miss blocked by valid slots
    imiss(2'd2, 32'h0000_4444);
    busy_slot(100);
    for (int k = 1; k <= 63; k++) busy_slot(100 + k);
    check("starve_63", 128'(rif.rra_starved), 128'(0));
    busy_slot(164);
    check("starve_64", 128'(rif.rra_starved), 128'(1));
    for (int k = 0; k < 3; k++) busy_slot(165 + k);
    check("starve_hold", 128'(rif.rra_starved), 128'(1));
    free_inject(mk_read(CT_ICACHE, 32'h0000_4440));
    check("starve_cleared", 128'(rif.rra_starved), 128'(0));
    iwake(2'd2);
    free_slot();
    check("starve_ipend_clear", 128'(rif.icache_miss_pending), 128'(0));

    // Same-cycle wake and new miss on thread 1
    dmiss(2'd1, 32'h5000_0010);
    free_slot();
    free_inject(mk_read(CT_DCACHE, 32'h5000_0000));
    dwake(2'd1);
    dmiss(2'd1, 32'h6000_0ABC);
    free_slot();
    check("rewake_dpend", 128'(rif.dcache_miss_pending), 128'(4'b0010));
    free_inject(mk_read(CT_DCACHE, 32'h6000_0A80));
    dwake(2'd1);
    free_slot();
    check("rewake_clear", 128'(rif.dcache_miss_pending), 128'(0));

    // Reset while entries are SENT, then stale wakes
    dmiss(2'd0, 32'h0000_7000);
    imiss(2'd3, 32'h0000_8040);
    free_slot();
    free_inject(mk_read(CT_DCACHE, 32'h0000_7000));
    free_inject(mk_read(CT_ICACHE, 32'h0000_8040));
    check("midrst_dpend_before", 128'(rif.dcache_miss_pending), 128'(4'b0001));
    check("midrst_ipend_before", 128'(rif.icache_miss_pending), 128'(4'b1000));
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_pkt_out", 128'(rif.packet_out), 128'(0));
    check("midrst_pend", 128'({rif.dcache_miss_pending, rif.icache_miss_pending}), 128'(0));
    check("midrst_starved", 128'(rif.rra_starved), 128'(0));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    dwake(2'd0);
    iwake(2'd3);
    free_slot();
    check("stale_wake_pend", 128'({rif.dcache_miss_pending, rif.icache_miss_pending}), 128'(0));
    free_slot();
    dmiss(2'd2, 32'h0000_9001);
    imiss(2'd2, 32'h0000_A0FF);
    free_slot();
    free_inject(mk_read(CT_DCACHE, 32'h0000_9000));
    free_inject(mk_read(CT_ICACHE, 32'h0000_A0C0));
    dwake(2'd2);
    iwake(2'd2);
    free_slot();
    free_slot();
    free_slot();
    check("final_pend", 128'({rif.dcache_miss_pending, rif.icache_miss_pending}), 128'(0));
    check("scoreboard_empty", 128'(q.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
